// File: rtl/flash_line_arbiter.sv
// flash_line_arbiter
//
// Shares one QSPI flash line-read engine between two line-fill requesters.
// Port 0 is the instruction cache and port 1 is the data cache / DMA. The block
// arbitrates round-robin and issues one line-aligned read per grant. It then
// counts the returned 32-bit beats and steers them to the owning port.
//
// Optional watchdog: define FLASH_ARB_TIMEOUT_EN to enable it. A stalled read
// is then aborted after TIMEOUT cycles without sequencer progress. Without the
// macro, rd_abort, err0 and err1 are tied low.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   req0/req1            line-fill requests (held until own last beat or err)
//   addr0/addr1          requested byte addresses, sampled at grant
//   gnt0/gnt1            ownership, high from issue through last beat
//   valid0/1, last0/1    beat strobe / final beat, routed to the owner only
//   err0/err1            one-cycle abort pulse to the owner
//   rdata                beat data (zero when no beat is being routed)
//   rd_req/rd_addr       line read request to the sequencer (held until rd_ack)
//   rd_ack               sequencer accepted the request
//   rd_valid/rd_data     beat stream from the sequencer
//   rd_abort             one-cycle abort to the sequencer
//   dbg_state            current FSM state (0 IDLE, 1 ISSUE, 2 XFER)
//
// Handshake: rd_req/rd_addr are a valid/ready pair with rd_ack as ready. The
// request is held stable until accepted. Beats (rd_valid) carry no back-pressure
// and are accepted whenever they arrive during ISSUE-with-ack or XFER.
module flash_line_arbiter #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              valid0,
  output logic              valid1,
  output logic              last0,
  output logic              last1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic              rd_abort,
  output logic [1:0]        dbg_state
);

  localparam int unsigned CntW = $clog2(BEATS);
  localparam int unsigned OffW = $clog2(BEATS * 4);
  localparam logic [ADDR_W-1:0] LineMask = {ADDR_W{1'b1}} << OffW;

  if (BEATS < 2 || BEATS > 16 || (BEATS & (BEATS - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("flash_line_arbiter: BEATS must be a power of two in 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, XFER = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   beat_q, beat_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rd_req_q, rd_req_d;
  logic              win;
  logic              beat_acc;
  logic              beat_last;
  logic              timeout_hit;

  // A beat that arrives together with rd_ack already belongs to this line.
  assign beat_acc  = rd_valid && ((state_q == XFER) || ((state_q == ISSUE) && rd_ack));
  assign beat_last = beat_acc && (beat_q == CntW'(BEATS - 1));

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           busy;
  logic           progress;

  assign busy     = (state_q != IDLE);
  assign progress = rd_ack || rd_valid;
  // Fires in the cycle in which the count would reach TIMEOUT.
  assign timeout_hit = busy && !progress && (wd_q == WdW'(TIMEOUT - 1));

  always_comb begin
    wd_d = '0;
    if (busy && !progress && !timeout_hit) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Held at zero in IDLE, so entry to ISSUE always starts from a clean count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign rd_abort = timeout_hit;
  assign err0     = timeout_hit && !owner_q;
  assign err1     = timeout_hit && owner_q;
`else
  assign timeout_hit = 1'b0;
  assign rd_abort    = 1'b0;
  assign err0        = 1'b0;
  assign err1        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    rd_req_d   = rd_req_q;
    win        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not own the last line wins.
          win      = (req0 && req1) ? ~last_gnt_q : req1;
          owner_d  = win;
          addr_d   = (win ? addr1 : addr0) & LineMask;
          beat_d   = '0;
          gnt0_d   = ~win;
          gnt1_d   = win;
          rd_req_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = XFER;
        end
        if (beat_acc) begin
          beat_d = beat_q + 1'b1;
        end
      end
      XFER: begin
        if (beat_last) begin
          gnt0_d     = 1'b0;
          gnt1_d     = 1'b0;
          beat_d     = '0;
          last_gnt_d = owner_q;
          state_d    = IDLE;
        end else if (beat_acc) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rd_req_d   = 1'b0;
      beat_d     = '0;
      last_gnt_d = owner_q;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      beat_q     <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rd_req_q   <= rd_req_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = addr_q;
  assign valid0    = beat_acc && !owner_q;
  assign valid1    = beat_acc && owner_q;
  assign last0     = beat_last && !owner_q;
  assign last1     = beat_last && owner_q;
  assign rdata     = beat_acc ? rd_data : 32'h0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flash_line_arbiter.sv
module tb_flash_line_arbiter;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int unsigned TO    = 8;
  localparam int          STALL = 6;
`else
  localparam int unsigned TO    = 255;
  localparam int          STALL = 10;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req0, req1;
  logic [23:0] addr0, addr1;
  logic        gnt0, gnt1, valid0, valid1, last0, last1, err0, err1;
  logic [31:0] rdata;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_ack, rd_valid;
  logic [31:0] rd_data;
  logic        rd_abort;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  flash_line_arbiter #(.ADDR_W(24), .BEATS(4), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
    .last0(last0), .last1(last1), .err0(err0), .err1(err1),
    .rdata(rdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_abort(rd_abort),
    .dbg_state(dbg_state)
  );

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid0"}, {31'b0, valid0}, 32'h0);
    chk({tag, "_valid1"}, {31'b0, valid1}, 32'h0);
    chk({tag, "_last0"}, {31'b0, last0}, 32'h0);
    chk({tag, "_last1"}, {31'b0, last1}, 32'h0);
    chk({tag, "_err0"}, {31'b0, err0}, 32'h0);
    chk({tag, "_err1"}, {31'b0, err1}, 32'h0);
    chk({tag, "_abort"}, {31'b0, rd_abort}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
  endtask

  // Entered in the first ISSUE cycle. Acks, delivers 4 beats with 'gap' idle
  // cycles before each, and returns in the cycle after the last beat.
  task automatic xfer(input bit port, input logic [31:0] base, input int gap);
    rd_ack = 1'b1;
    #1;
    chk("issue_rd_req", {31'b0, rd_req}, 32'h1);
    tick();
    rd_ack = 1'b0;
    #1;
    chk("xfer_rd_req_low", {31'b0, rd_req}, 32'h0);
    chk("xfer_gnt", {31'b0, (port ? gnt1 : gnt0)}, 32'h1);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        rd_valid = 1'b0;
        #1;
        chk("gap_quiet_valid", {31'b0, (valid0 | valid1)}, 32'h0);
        chk("gap_quiet_last", {31'b0, (last0 | last1)}, 32'h0);
        tick();
      end
      rd_valid = 1'b1;
      rd_data  = base + b;
      #1;
      chk("beat_valid_owner", {31'b0, (port ? valid1 : valid0)}, 32'h1);
      chk("beat_valid_other", {31'b0, (port ? valid0 : valid1)}, 32'h0);
      chk("beat_last_owner", {31'b0, (port ? last1 : last0)}, (b == 3) ? 32'h1 : 32'h0);
      chk("beat_last_other", {31'b0, (port ? last0 : last1)}, 32'h0);
      chk("beat_rdata", rdata, base + b);
      tick();
    end
    rd_valid = 1'b0;
    #1;
    chk("after_last_gnt0", {31'b0, gnt0}, 32'h0);
    chk("after_last_gnt1", {31'b0, gnt1}, 32'h0);
    chk("after_last_state", {30'b0, dbg_state}, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    HRESETn  = 1'b0;
    req0     = 1'b0;
    req1     = 1'b0;
    addr0    = '0;
    addr1    = '0;
    rd_ack   = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_gnt0", {31'b0, gnt0}, 32'h0);
    chk("reset_gnt1", {31'b0, gnt1}, 32'h0);
    chk("reset_rd_req", {31'b0, rd_req}, 32'h0);
    chk("reset_rd_addr", {8'b0, rd_addr}, 32'h0);
    chk("reset_state", {30'b0, dbg_state}, 32'h0);
    HRESETn = 1'b1;
    tick();

    // Tie from reset: port 0 first.
    req0 = 1'b1; addr0 = 24'h000123;
    req1 = 1'b1; addr1 = 24'h00ABCD;
    #1;
    chk("tie_latency_gnt0", {31'b0, gnt0}, 32'h0);
    tick();
    chk("tie_gnt0", {31'b0, gnt0}, 32'h1);
    chk("tie_gnt1", {31'b0, gnt1}, 32'h0);
    chk("tie_rd_req", {31'b0, rd_req}, 32'h1);
    chk("tie_rd_addr0", {8'b0, rd_addr}, 32'h000120);
    xfer(1'b0, 32'hA0, 0);
    req0 = 1'b0;
    #1;
    chk("idle_gap_gnt1", {31'b0, gnt1}, 32'h0);
    tick();
    chk("tie_second_gnt1", {31'b0, gnt1}, 32'h1);
    chk("tie_rd_addr1", {8'b0, rd_addr}, 32'h00ABC0);
    xfer(1'b1, 32'hB0, 0);
    // Fresh tie: port 1 owned last, so port 0 wins.
    req0 = 1'b1;
    tick();
    chk("fresh_tie_gnt0", {31'b0, gnt0}, 32'h1);
    chk("fresh_tie_gnt1", {31'b0, gnt1}, 32'h0);
    xfer(1'b0, 32'hC0, 0);
    req0 = 1'b0;
    tick();

    // Stalled issue on port 1.
    chk("stall_gnt1", {31'b0, gnt1}, 32'h1);
    for (int i = 0; i < STALL; i++) begin
      chk("stall_rd_req", {31'b0, rd_req}, 32'h1);
      chk("stall_rd_addr", {8'b0, rd_addr}, 32'h00ABC0);
      chk("stall_gnt", {31'b0, gnt1}, 32'h1);
      chk_quiet("stall");
      tick();
    end

    // Gapped beats on port 1, then stray beats after last are ignored.
    xfer(1'b1, 32'hD0, 3);
    req1 = 1'b0;
    rd_valid = 1'b1; rd_data = 32'h5A5A5A5A;
    #1;
    chk_quiet("stray_beat_idle");
    tick();
    chk_quiet("stray_beat_idle2");
    rd_valid = 1'b0;
    tick();

    // Single request on port 0.
    req0 = 1'b1; addr0 = 24'h000123;
    tick();
    chk("single_gnt0", {31'b0, gnt0}, 32'h1);
    chk("single_rd_req", {31'b0, rd_req}, 32'h1);
    chk("single_rd_addr", {8'b0, rd_addr}, 32'h000120);
    xfer(1'b0, 32'hA0, 0);
    req0 = 1'b0;
    tick();

    // Reset in the middle of XFER after two beats.
    req0 = 1'b1; addr0 = 24'h000200;
    tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rd_valid = 1'b1; rd_data = 32'h70 + b;
      tick();
    end
    HRESETn = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst_gnt0", {31'b0, gnt0}, 32'h0);
    chk("midrst_rd_req", {31'b0, rd_req}, 32'h0);
    chk("midrst_rd_addr", {8'b0, rd_addr}, 32'h0);
    rd_valid = 1'b0;
    req0 = 1'b0;
    tick();
    HRESETn = 1'b1;
    req1 = 1'b1; addr1 = 24'h000345;
    tick();
    chk("postrst_gnt1", {31'b0, gnt1}, 32'h1);
    chk("postrst_gnt0", {31'b0, gnt0}, 32'h0);
    chk("postrst_rd_addr", {8'b0, rd_addr}, 32'h000340);
    xfer(1'b1, 32'hE0, 0);
    req1 = 1'b0;
    tick();

`ifdef FLASH_ARB_TIMEOUT_EN
    // Watchdog: ack, then silence; abort on the 8th idle cycle.
    req0 = 1'b1; addr0 = 24'h010000;
    tick();
    chk("to_gnt0", {31'b0, gnt0}, 32'h1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    req1 = 1'b1; addr1 = 24'h000400;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("to_abort", {31'b0, rd_abort}, (k == 8) ? 32'h1 : 32'h0);
      chk("to_err0", {31'b0, err0}, (k == 8) ? 32'h1 : 32'h0);
      chk("to_err1", {31'b0, err1}, 32'h0);
      tick();
    end
    req0 = 1'b0;
    #1;
    chk("to_after_gnt0", {31'b0, gnt0}, 32'h0);
    chk("to_after_rd_req", {31'b0, rd_req}, 32'h0);
    chk("to_after_abort", {31'b0, rd_abort}, 32'h0);
    chk("to_after_state", {30'b0, dbg_state}, 32'h0);
    tick();
    chk("to_next_gnt1", {31'b0, gnt1}, 32'h1);
    chk("to_next_rd_addr", {8'b0, rd_addr}, 32'h000400);
    xfer(1'b1, 32'hF0, 0);
    req1 = 1'b0;
    tick();
`else
    // Without the watchdog a long silent transfer is never aborted.
    req0 = 1'b1; addr0 = 24'h010000;
    tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk_quiet("no_wd");
      chk("no_wd_gnt0", {31'b0, gnt0}, 32'h1);
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      rd_valid = 1'b1; rd_data = 32'hF0 + b;
      #1;
      chk("no_wd_beat", {31'b0, valid0}, 32'h1);
      tick();
    end
    rd_valid = 1'b0;
    req0 = 1'b0;
    #1;
    chk("no_wd_done_gnt0", {31'b0, gnt0}, 32'h0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
